// File: rtl/nibble_word_rx.sv
// Nibble-to-word receiver: packs WIDTH/4 handshaked nibbles into one word and
// presents it on a registered valid/ready stage; flushes stale partial words.
module nibble_word_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_nibble,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             err_flush,
    output logic             busy
);

    localparam int unsigned NUM   = WIDTH / 4;
    localparam int unsigned CNT_W = $clog2(NUM);
    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] LAST      = CNT_W'(NUM - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [GAP_W-1:0]   gap;
    logic [GAP_W-1:0]   gap_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic               out_valid_next;
    logic [WIDTH-1:0]   out_data_next;
    logic               err_flush_next;

    logic               accept;
    logic               xfer;
    logic               timeout_hit;
    logic [SH_W-1:0]    sh;
    logic [WIDTH-1:0]   merged;

    // Only the word-completing nibble has to wait for the output register.
    assign in_ready = !((cnt == LAST) && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign busy     = (state == FILL);

    assign timeout_hit = (TIMEOUT > 0) && (state == FILL) && !accept && (gap == GAP_LIMIT);

    // Bit offset of the slot addressed by cnt.
    always_comb begin
        sh = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (cnt == CNT_W'(k)) begin
                sh = MSB_FIRST ? SH_W'(WIDTH - 4 - 4 * k) : SH_W'(4 * k);
            end
        end
    end

    // Accumulator with the incoming nibble dropped into its slot.
    assign merged = (acc & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(in_nibble) << sh);

    // Next-state and datapath decisions.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        gap_next       = gap;
        acc_next       = acc;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        err_flush_next = 1'b0;

        if (xfer) begin
            out_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FILL;
                    cnt_next   = cnt + CNT_W'(1);
                    gap_next   = '0;
                    acc_next   = merged;
                end
            end
            FILL: begin
                if (accept) begin
                    gap_next = '0;
                    if (cnt == LAST) begin
                        // A completing word may replace one leaving in the same cycle.
                        state_next     = IDLE;
                        cnt_next       = '0;
                        acc_next       = '0;
                        out_valid_next = 1'b1;
                        out_data_next  = merged;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                        acc_next = merged;
                    end
                end else if (timeout_hit) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    gap_next       = '0;
                    acc_next       = '0;
                    err_flush_next = 1'b1;
                end else if (TIMEOUT > 0) begin
                    gap_next = gap + GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_flush <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            gap       <= gap_next;
            acc       <= acc_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            err_flush <= err_flush_next;
        end
    end

endmodule

// File: tb/tb_nibble_word_rx.sv
// Bench for nibble_word_rx: queue-based reference model checked every cycle on the
// main 8-bit MSB-first instance, plus directed literals on LSB-first and 16-bit instances.
module tb_nibble_word_rx;

    localparam int unsigned TB_W   = 8;
    localparam int unsigned TB_NUM = TB_W / 4;
    localparam int unsigned TB_TO  = 15;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            in_valid  = 1'b0;
    logic [3:0]      in_nibble = 4'h0;
    logic            out_ready = 1'b1;
    logic            in_ready;
    logic            out_valid;
    logic [TB_W-1:0] out_data;
    logic            err_flush;
    logic            busy;

    logic            s_ready = 1'b1;
    logic [3:0]      s_nib   = 4'h0;
    logic            l_valid = 1'b0;
    logic            w_valid = 1'b0;
    logic            l_in_ready, l_ov, l_err, l_busy;
    logic [7:0]      l_od;
    logic            w_in_ready, w_ov, w_err, w_busy;
    logic [15:0]     w_od;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  got;
    logic seen;
    time t0;

    always #5 clk = ~clk;

    nibble_word_rx #(.WIDTH(TB_W), .MSB_FIRST(1'b1), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_nibble(in_nibble),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .err_flush(err_flush), .busy(busy)
    );

    nibble_word_rx #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(TB_TO)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(l_valid), .in_nibble(s_nib),
        .in_ready(l_in_ready), .out_valid(l_ov), .out_data(l_od),
        .out_ready(s_ready), .err_flush(l_err), .busy(l_busy)
    );

    nibble_word_rx #(.WIDTH(16), .MSB_FIRST(1'b1), .TIMEOUT(TB_TO)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_nibble(s_nib),
        .in_ready(w_in_ready), .out_valid(w_ov), .out_data(w_od),
        .out_ready(s_ready), .err_flush(w_err), .busy(w_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: partial word as a queue of nibbles, one-entry output slot.
    logic [3:0]      m_q[$];
    int              m_gap = 0;
    logic            m_ov  = 1'b0;
    logic [TB_W-1:0] m_od  = '0;
    logic            m_err = 1'b0;

    function automatic logic m_ready();
        return !((m_q.size() == int'(TB_NUM - 1)) && m_ov && !out_ready);
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic            take;
        logic            done;
        logic [TB_W-1:0] word;
        if (!rst) begin
            m_q.delete();
            m_gap = 0;
            m_ov  = 1'b0;
            m_od  = '0;
            m_err = 1'b0;
        end else begin
            take  = in_valid && m_ready();
            done  = 1'b0;
            m_err = 1'b0;
            if (take) begin
                m_q.push_back(in_nibble);
                m_gap = 0;
                if (m_q.size() == int'(TB_NUM)) begin
                    word = '0;
                    for (int i = 0; i < m_q.size(); i++) word = (word << 4) | TB_W'(m_q[i]);
                    m_od = word;
                    m_ov = 1'b1;
                    m_q.delete();
                    done = 1'b1;
                end
            end else if (m_q.size() > 0) begin
                m_gap++;
                if (m_gap == int'(TB_TO)) begin
                    m_q.delete();
                    m_gap = 0;
                    m_err = 1'b1;
                end
            end
            if (!done && m_ov && out_ready) m_ov = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("in_ready",  32'(in_ready),  32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data",  32'(out_data),  32'(m_od));
        check("err_flush", 32'(err_flush), 32'(m_err));
        check("busy",      32'(busy),      32'(m_q.size() > 0));
    end

    // Offer one nibble until accepted (bounded).
    task automatic push(input logic [3:0] n);
        logic ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_nibble = n;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_nibble = 4'hx;
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic spush(input logic lv, input logic wv, input logic [3:0] n);
        l_valid = lv;
        w_valid = wv;
        s_nib   = n;
        @(posedge clk);
        #1;
        l_valid = 1'b0;
        w_valid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_err_flush", 32'(err_flush), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc();

        // Basic MSB-first word, valid for exactly one cycle.
        push(4'hA);
        push(4'h5);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  32'(out_data),  32'hA5);
        cyc();
        check("t1_valid_drop", 32'(out_valid), 32'd0);

        // LSB-first and 16-bit instances.
        spush(1'b1, 1'b0, 4'hA);
        spush(1'b1, 1'b0, 4'h5);
        check("t2_lsb_valid", 32'(l_ov), 32'd1);
        check("t2_lsb_data",  32'(l_od), 32'h5A);
        spush(1'b0, 1'b1, 4'h1);
        spush(1'b0, 1'b1, 4'h2);
        spush(1'b0, 1'b1, 4'h3);
        check("t2_w16_busy", 32'(w_busy), 32'd1);
        spush(1'b0, 1'b1, 4'h4);
        check("t2_w16_valid", 32'(w_ov), 32'd1);
        check("t2_w16_data",  32'(w_od), 32'h1234);
        check("t2_lsb_drop",  32'(l_ov), 32'd0);

        // Back-pressure: final nibble stalls behind the pending word.
        out_ready = 1'b0;
        push(4'hA);
        push(4'h5);
        push(4'h1);
        in_valid  = 1'b1;
        in_nibble = 4'h2;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall", 32'(in_ready), 32'd0);
            cyc();
        end
        check("t3_hold", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release", 32'(in_ready), 32'd1);
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_data",  32'(out_data),  32'h12);
        out_ready = 1'b1;
        cyc();
        check("t3_drain", 32'(out_valid), 32'd0);

        // Streaming: eight nibbles on eight consecutive cycles.
        t0 = $time;
        push(4'h1); push(4'h2); check("t4_w0", 32'(out_data), 32'h12);
        push(4'h3); push(4'h4); check("t4_w1", 32'(out_data), 32'h34);
        push(4'h5); push(4'h6); check("t4_w2", 32'(out_data), 32'h56);
        push(4'h7); push(4'h8); check("t4_w3", 32'(out_data), 32'h78);
        check("t4_cycles", 32'(($time - t0) / 10), 32'd8);
        cyc();

        // Timeout flush 15 cycles after the lone accept.
        push(4'h3);
        got = 0;
        for (int i = 1; i <= 40 && got == 0; i++) begin
            cyc();
            if (err_flush) got = i;
        end
        check("t5_flush_delay", 32'(got), 32'd15);
        check("t5_busy", 32'(busy), 32'd0);
        cyc();
        check("t5_pulse_len", 32'(err_flush), 32'd0);
        push(4'h4);
        push(4'h6);
        check("t5_data", 32'(out_data), 32'h46);

        // Second nibble arrives while gap is 14: no flush.
        push(4'h3);
        seen = 1'b0;
        repeat (14) begin
            cyc();
            seen = seen | err_flush;
        end
        push(4'h5);
        seen = seen | err_flush;
        check("t5_no_flush", 32'(seen), 32'd0);
        check("t5_late_data", 32'(out_data), 32'h35);
        cyc();

        // Asynchronous reset mid-word.
        push(4'h7);
        #2 rst = 1'b0;
        #1;
        check("t6_mid_busy",  32'(busy),      32'd0);
        check("t6_mid_valid", 32'(out_valid), 32'd0);
        check("t6_mid_data",  32'(out_data),  32'd0);
        check("t6_mid_err",   32'(err_flush), 32'd0);
        cyc();
        rst = 1'b1;

        // Asynchronous reset with a word pending.
        out_ready = 1'b0;
        push(4'hA);
        push(4'h5);
        check("t6_pend_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data",  32'(out_data),  32'd0);
        cyc();
        rst       = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("t6_rst_err", 32'(err_flush), 32'd0);
        push(4'h8);
        push(4'h9);
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_data",  32'(out_data),  32'h89);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
